hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, bubble cycles per load-use hazard; legal range 1..4.
REQ-003 SHALL have parameter FWD_EN, default 1; 1 = forwarding with load-use stall, 0 = no forwarding, stall on every RAW.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have ports:
  - CLK  in  1  clock, all state updates on its rising edge.
  - RESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
  - id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
  - id_use1, id_use2  in  1  ID instruction actually reads rs1/rs2.
  - ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX.
  - ex_rd  in  REG_AW; ex_regwrite, ex_memread  in  1  EX destination, write enable, load flag.
  - mem_rd  in  REG_AW; mem_regwrite, mem_memread  in  1  MEM destination, write enable, load flag.
  - wb_rd  in  REG_AW; wb_regwrite  in  1  WB destination and write enable.
  - branch_taken  in  1  taken branch/jump resolved in MEM this cycle.
  - perf_clr  in  1  synchronous clear of both counters.
  - pc_en, ifid_en  out  1  PC and IF/ID register enables.
  - ifid_clr, idex_clr, exmem_clr  out  1  synchronous bubble insertion into IF/ID, ID/EX, EX/MEM.
  - fwd_a, fwd_b  out  2  ALU operand select: 00 = register file, 01 = WB value, 10 = MEM ALU result.
  - stall_cnt, flush_cnt  out  CNT_W  stall cycles and flush events since reset or clear.

Function
REQ-006 SHALL implement FSM states RUN and STALL, plus a down-counter lat_cnt of width clog2(LOAD_LAT+1).
REQ-007 SHALL treat a register match as valid only when the destination is nonzero, its write enable is 1, and, for ID sources, the corresponding id_use bit is 1.
REQ-008 SHALL detect a load-use hazard (FWD_EN=1) when ex_memread=1 and ex_rd matches a valid ID source.
REQ-009 SHALL detect a RAW hazard (FWD_EN=0) when ex_rd or mem_rd matches a valid ID source; WB needs no stall because the register file writes before it reads.
REQ-010 SHALL, on a hazard in RUN, drive pc_en=0, ifid_en=0 and idex_clr=1 in the same cycle, with zero-cycle combinational latency.
REQ-011 SHALL, on a load-use hazard in RUN with LOAD_LAT>1, enter STALL with lat_cnt=LOAD_LAT-1; with LOAD_LAT=1, remain in RUN.
REQ-012 SHALL, in STALL, drive pc_en=0, ifid_en=0, idex_clr=1 and decrement lat_cnt each cycle, returning to RUN after the cycle in which lat_cnt=1.
REQ-013 SHALL, for FWD_EN=0, re-evaluate the RAW hazard every cycle in RUN; the stall persists while the condition holds and uses no counter.
REQ-014 SHALL, on branch_taken=1 in any state, drive ifid_clr=1, idex_clr=1, exmem_clr=1 and pc_en=1; branch_taken overrides any stall, aborts STALL, forces RUN and clears lat_cnt.
REQ-015 SHALL, when no hazard and no branch_taken, drive pc_en=1, ifid_en=1 and all clr=0.
REQ-016 SHALL compute fwd_a (FWD_EN=1) as:
  - 10 if mem_regwrite=1, mem_memread=0, mem_rd!=0 and mem_rd==ex_rs1;
  - else 01 if wb_regwrite=1, wb_rd!=0 and wb_rd==ex_rs1;
  - else 00.
REQ-017 SHALL compute fwd_b identically using ex_rs2; MEM has priority over WB, so the newest value wins.
REQ-018 SHALL hold fwd_a=fwd_b=00 when FWD_EN=0.
REQ-019 SHALL increment stall_cnt on every cycle with pc_en=0, and flush_cnt on every cycle with branch_taken=1.
REQ-020 SHALL make both counters saturate at 2^CNT_W-1 with no wrap.
REQ-021 SHALL give perf_clr priority over increment; the clear cycle's event is not counted.

Reset
REQ-022 SHALL, while RESET_N=0, force state=RUN, lat_cnt=0, stall_cnt=0, flush_cnt=0, pc_en=0, ifid_en=0, all clr=1, fwd_a=fwd_b=00.
REQ-023 SHALL, on reset assertion during STALL, abandon the stall immediately; first cycle after release is RUN with no residual bubble.

Verification
REQ-024 SHALL be verified with load-use, LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs1=5, id_use1=1 -> one cycle pc_en=0/idex_clr=1; next cycle consumer in EX sees fwd_a=01 with wb_rd=5.
REQ-025 SHALL be verified with LOAD_LAT=3, same stimulus -> exactly 3 consecutive stall cycles, stall_cnt=3, then pc_en=1.
REQ-026 SHALL be verified with double forward: mem_rd=wb_rd=ex_rs2=7, both regwrite=1, mem_memread=0 -> fwd_b=10; mem_rd=0 instead -> fwd_b=01.
REQ-027 SHALL be verified with branch_taken=1 in second cycle of a LOAD_LAT=3 stall -> all three clr=1, pc_en=1 that cycle, state RUN next cycle, flush_cnt=1.
REQ-028 SHALL be verified with FWD_EN=0: ex_rd=3 then mem_rd=3 matching id_rs2 -> two stall cycles, fwd_a=fwd_b=00 throughout; ex_rd=0 match -> no stall.
REQ-029 SHALL be verified with CNT_W=4 and 20 stall cycles -> stall_cnt holds 15; perf_clr coincident with a stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard unit: register indices, write/load flags in,
// stage enables, bubble controls, forwarding selects and perf counters out.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic              mem_memread;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic              branch_taken;
    logic              perf_clr;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_clr;
    logic              idex_clr;
    logic              exmem_clr;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
               wb_rd, wb_regwrite, branch_taken, perf_clr,
        input  pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
               wb_rd, wb_regwrite, branch_taken, perf_clr,
        output pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use / RAW stall generation, taken-branch
// flush, EX operand forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          CLK,
    input  logic          RESET_N,
    hazard_ctrl_if.slave  bus
);
    localparam int unsigned       LAT_W     = $clog2(LOAD_LAT + 1);
    localparam logic [REG_AW-1:0] REG_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam bit                USE_FWD   = (FWD_EN != 0);
    localparam bit                MULTI_LAT = (LOAD_LAT > 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       ex_hit_c, mem_hit_c, hazard_c;
    logic       mem_fwd_ok_c, wb_fwd_ok_c;
    logic       pc_en_c, ifid_en_c, ifid_clr_c, idex_clr_c, exmem_clr_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // A producer only counts when it really writes a nonzero register the ID instruction reads
    always_comb begin
        ex_hit_c  = bus.ex_regwrite && (bus.ex_rd != REG_ZERO) &&
                    ((bus.id_use1 && (bus.ex_rd == bus.id_rs1)) ||
                     (bus.id_use2 && (bus.ex_rd == bus.id_rs2)));
        mem_hit_c = bus.mem_regwrite && (bus.mem_rd != REG_ZERO) &&
                    ((bus.id_use1 && (bus.mem_rd == bus.id_rs1)) ||
                     (bus.id_use2 && (bus.mem_rd == bus.id_rs2)));
        hazard_c  = USE_FWD ? (ex_hit_c && bus.ex_memread) : (ex_hit_c || mem_hit_c);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RUN;
            lat_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Control outputs are combinational so a hazard freezes the front end in the same cycle
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        pc_en_c     = 1'b1;
        ifid_en_c   = 1'b1;
        ifid_clr_c  = 1'b0;
        idex_clr_c  = 1'b0;
        exmem_clr_c = 1'b0;
        if (!RESET_N) begin
            pc_en_c     = 1'b0;
            ifid_en_c   = 1'b0;
            ifid_clr_c  = 1'b1;
            idex_clr_c  = 1'b1;
            exmem_clr_c = 1'b1;
            state_d     = RUN;
            lat_cnt_d   = '0;
        end else if (bus.branch_taken) begin
            ifid_clr_c  = 1'b1;
            idex_clr_c  = 1'b1;
            exmem_clr_c = 1'b1;
            state_d     = RUN;
            lat_cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_c) begin
                        pc_en_c    = 1'b0;
                        ifid_en_c  = 1'b0;
                        idex_clr_c = 1'b1;
                        if (USE_FWD && MULTI_LAT) begin
                            state_d   = STALL;
                            lat_cnt_d = LAT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_clr_c = 1'b1;
                    lat_cnt_d  = lat_cnt_q - LAT_W'(1);
                    if (lat_cnt_q <= LAT_W'(1)) begin
                        state_d   = RUN;
                        lat_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = RUN;
                    lat_cnt_d = '0;
                end
            endcase
        end
    end

    // MEM result beats WB so the youngest producer wins; loads in MEM have no ALU result yet
    always_comb begin
        mem_fwd_ok_c = bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd != REG_ZERO);
        wb_fwd_ok_c  = bus.wb_regwrite && (bus.wb_rd != REG_ZERO);
        fwd_a_c      = 2'b00;
        fwd_b_c      = 2'b00;
        if (USE_FWD && RESET_N) begin
            if (mem_fwd_ok_c && (bus.mem_rd == bus.ex_rs1)) begin
                fwd_a_c = 2'b10;
            end else if (wb_fwd_ok_c && (bus.wb_rd == bus.ex_rs1)) begin
                fwd_a_c = 2'b01;
            end
            if (mem_fwd_ok_c && (bus.mem_rd == bus.ex_rs2)) begin
                fwd_b_c = 2'b10;
            end else if (wb_fwd_ok_c && (bus.wb_rd == bus.ex_rs2)) begin
                fwd_b_c = 2'b01;
            end
        end
    end

    // Saturating counters; a clear swallows the event of its own cycle
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_en_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bus.branch_taken && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en     = pc_en_c;
    assign bus.ifid_en   = ifid_en_c;
    assign bus.ifid_clr  = ifid_clr_c;
    assign bus.idex_clr  = idex_clr_c;
    assign bus.exmem_clr = exmem_clr_c;
    assign bus.fwd_a     = fwd_a_c;
    assign bus.fwd_b     = fwd_b_c;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Drives four differently-parameterised hazard_ctrl instances with one shared stimulus
// and checks each against a bubble-count reference model, plus directed literal cases.
module tb_hazard_ctrl;
    localparam int N = 4;
    // instance:             3      2      1      0
    localparam logic [N-1:0][7:0] LLP = {8'd4,  8'd2,  8'd3,  8'd1};
    localparam logic [N-1:0][7:0] FEP = {8'd1,  8'd0,  8'd1,  8'd1};
    localparam logic [N-1:0][7:0] CWP = {8'd4,  8'd16, 8'd16, 8'd16};

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, mem_memread;
    logic wb_regwrite, branch_taken, perf_clr;

    logic        pc_en_o [N];
    logic        ifid_en_o [N];
    logic        ifid_clr_o [N];
    logic        idex_clr_o [N];
    logic        exmem_clr_o [N];
    logic [1:0]  fwd_a_o [N];
    logic [1:0]  fwd_b_o [N];
    logic [15:0] stall_o [N];
    logic [15:0] flush_o [N];

    int errors = 0;
    int checks = 0;

    // reference model state: bubbles still owed, and the two counters
    int rem [N];
    int scnt [N];
    int fcnt [N];
    int rem_n [N];
    int scnt_n [N];
    int fcnt_n [N];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned CW = CWP[g];
        hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus ();
        hazard_ctrl #(
            .REG_AW(5), .LOAD_LAT(LLP[g]), .FWD_EN(FEP[g]), .CNT_W(CW)
        ) u_dut (
            .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
        );
        assign bus.id_rs1       = id_rs1;
        assign bus.id_rs2       = id_rs2;
        assign bus.id_use1      = id_use1;
        assign bus.id_use2      = id_use2;
        assign bus.ex_rs1       = ex_rs1;
        assign bus.ex_rs2       = ex_rs2;
        assign bus.ex_rd        = ex_rd;
        assign bus.ex_regwrite  = ex_regwrite;
        assign bus.ex_memread   = ex_memread;
        assign bus.mem_rd       = mem_rd;
        assign bus.mem_regwrite = mem_regwrite;
        assign bus.mem_memread  = mem_memread;
        assign bus.wb_rd        = wb_rd;
        assign bus.wb_regwrite  = wb_regwrite;
        assign bus.branch_taken = branch_taken;
        assign bus.perf_clr     = perf_clr;
        assign pc_en_o[g]       = bus.pc_en;
        assign ifid_en_o[g]     = bus.ifid_en;
        assign ifid_clr_o[g]    = bus.ifid_clr;
        assign idex_clr_o[g]    = bus.idex_clr;
        assign exmem_clr_o[g]   = bus.exmem_clr;
        assign fwd_a_o[g]       = bus.fwd_a;
        assign fwd_b_o[g]       = bus.fwd_b;
        assign stall_o[g]       = 16'(bus.stall_cnt);
        assign flush_o[g]       = 16'(bus.flush_cnt);
    end

    function automatic bit id_hit(input logic [4:0] rd, input logic we);
        return we && (rd != 5'd0) &&
               ((id_use1 && (rd == id_rs1)) || (id_use2 && (rd == id_rs2)));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (mem_regwrite && !mem_memread && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // per-cycle comparison of every instance against the model
    always @(negedge CLK) begin : model_cmp
        bit pc, ie, c_if, c_ix, c_xm, haz, fe;
        logic [1:0] fa, fb;
        int cmax, ll;
        logic [40:0] e, a;
        for (int i = 0; i < N; i++) begin
            ll   = int'(LLP[i]);
            fe   = (FEP[i] != 8'd0);
            cmax = (1 << int'(CWP[i])) - 1;
            if (!RESET_N) begin
                pc = 0; ie = 0; c_if = 1; c_ix = 1; c_xm = 1; fa = 2'b00; fb = 2'b00;
                e = {pc, ie, c_if, c_ix, c_xm, fa, fb, 16'd0, 16'd0};
                rem_n[i] = 0; scnt_n[i] = 0; fcnt_n[i] = 0;
            end else begin
                haz = fe ? (id_hit(ex_rd, ex_regwrite) && ex_memread)
                         : (id_hit(ex_rd, ex_regwrite) || id_hit(mem_rd, mem_regwrite));
                c_if = 0; c_ix = 0; c_xm = 0; pc = 1; ie = 1;
                if (branch_taken) begin
                    c_if = 1; c_ix = 1; c_xm = 1;
                    rem_n[i] = 0;
                end else if (rem[i] > 0 || haz) begin
                    pc = 0; ie = 0; c_ix = 1;
                    rem_n[i] = (rem[i] > 0) ? rem[i] - 1 : (fe ? ll - 1 : 0);
                end else begin
                    rem_n[i] = 0;
                end
                fa = fe ? fsel(ex_rs1) : 2'b00;
                fb = fe ? fsel(ex_rs2) : 2'b00;
                e = {pc, ie, c_if, c_ix, c_xm, fa, fb, 16'(scnt[i]), 16'(fcnt[i])};
                scnt_n[i] = perf_clr ? 0 : (!pc ? sat_inc(scnt[i], cmax) : scnt[i]);
                fcnt_n[i] = perf_clr ? 0 : (branch_taken ? sat_inc(fcnt[i], cmax) : fcnt[i]);
            end
            a = {pc_en_o[i], ifid_en_o[i], ifid_clr_o[i], idex_clr_o[i], exmem_clr_o[i],
                 fwd_a_o[i], fwd_b_o[i], stall_o[i], flush_o[i]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model inst%0d t=%0t got=%h expected=%h", i, $time, a, e);
            end
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            rem[i]  <= rem_n[i];
            scnt[i] <= scnt_n[i];
            fcnt[i] <= fcnt_n[i];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0;
        wb_rd = 0; wb_regwrite = 0; branch_taken = 0; perf_clr = 0;
    endtask

    task automatic load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use1 = 1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_inputs();
        RESET_N      = ($urandom_range(0, 99) != 0);
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_use1      = ($urandom_range(0, 9) < 7);
        id_use2      = ($urandom_range(0, 9) < 7);
        ex_rs1       = 5'($urandom_range(0, 3));
        ex_rs2       = 5'($urandom_range(0, 3));
        ex_rd        = 5'($urandom_range(0, 3));
        ex_regwrite  = ($urandom_range(0, 9) < 6);
        ex_memread   = ($urandom_range(0, 9) < 3);
        mem_rd       = 5'($urandom_range(0, 3));
        mem_regwrite = ($urandom_range(0, 9) < 6);
        mem_memread  = ($urandom_range(0, 9) < 3);
        wb_rd        = 5'($urandom_range(0, 3));
        wb_regwrite  = ($urandom_range(0, 9) < 6);
        branch_taken = ($urandom_range(0, 11) == 0);
        perf_clr     = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        idle();
        RESET_N = 0;
        @(negedge CLK);
        chk("rst_pc_en", pc_en_o[1], 0);
        chk("rst_ifid_en", ifid_en_o[1], 0);
        chk("rst_ifid_clr", ifid_clr_o[1], 1);
        chk("rst_idex_clr", idex_clr_o[1], 1);
        chk("rst_exmem_clr", exmem_clr_o[1], 1);
        chk("rst_fwd_a", fwd_a_o[1], 0);
        chk("rst_stall_cnt", stall_o[1], 0);
        step(); step();
        RESET_N = 1;
        @(negedge CLK);
        chk("idle_pc_en", pc_en_o[1], 1);

        // load-use, LOAD_LAT=1 (inst0) and LOAD_LAT=3 (inst1)
        step(); load_use();
        @(negedge CLK);
        chk("lu1_pc_en", pc_en_o[0], 0);
        chk("lu1_idex_clr", idex_clr_o[0], 1);
        chk("lu3_c1_pc_en", pc_en_o[1], 0);
        step(); idle(); ex_rs1 = 5'd5; wb_rd = 5'd5; wb_regwrite = 1;
        @(negedge CLK);
        chk("lu1_resume_pc_en", pc_en_o[0], 1);
        chk("lu1_fwd_a_wb", fwd_a_o[0], 1);
        chk("lu3_c2_pc_en", pc_en_o[1], 0);
        step(); idle();
        @(negedge CLK);
        chk("lu3_c3_pc_en", pc_en_o[1], 0);
        step();
        @(negedge CLK);
        chk("lu3_done_pc_en", pc_en_o[1], 1);
        chk("lu3_stall_cnt", stall_o[1], 3);
        chk("lu1_stall_cnt", stall_o[0], 1);
        step(); step();

        // double forward: MEM beats WB, then WB alone
        idle(); mem_rd = 5'd7; wb_rd = 5'd7; ex_rs2 = 5'd7; mem_regwrite = 1; wb_regwrite = 1;
        @(negedge CLK);
        chk("dfwd_mem", fwd_b_o[0], 2);
        chk("dfwd_nofwd_inst", fwd_b_o[2], 0);
        step(); mem_rd = 5'd0;
        @(negedge CLK);
        chk("dfwd_wb", fwd_b_o[0], 1);

        // branch in second cycle of a LOAD_LAT=3 stall
        step(); idle(); load_use();
        @(negedge CLK);
        chk("br_stall_pc_en", pc_en_o[1], 0);
        step(); idle(); branch_taken = 1;
        @(negedge CLK);
        chk("br_ifid_clr", ifid_clr_o[1], 1);
        chk("br_idex_clr", idex_clr_o[1], 1);
        chk("br_exmem_clr", exmem_clr_o[1], 1);
        chk("br_pc_en", pc_en_o[1], 1);
        step(); idle();
        @(negedge CLK);
        chk("br_after_pc_en", pc_en_o[1], 1);
        chk("br_flush_cnt", flush_o[1], 1);

        // no forwarding: EX then MEM producer of id_rs2, then a zero-register match
        step(); idle(); id_rs2 = 5'd3; id_use2 = 1; ex_rd = 5'd3; ex_regwrite = 1;
        ex_rs1 = 5'd3; ex_rs2 = 5'd3;
        @(negedge CLK);
        chk("raw_ex_pc_en", pc_en_o[2], 0);
        chk("raw_ex_fwd_a", fwd_a_o[2], 0);
        chk("raw_ex_fwd_b", fwd_b_o[2], 0);
        step(); ex_rd = 5'd0; ex_regwrite = 0; mem_rd = 5'd3; mem_regwrite = 1;
        @(negedge CLK);
        chk("raw_mem_pc_en", pc_en_o[2], 0);
        chk("raw_mem_fwd_b", fwd_b_o[2], 0);
        step(); mem_rd = 5'd0; mem_regwrite = 0; id_rs2 = 5'd0; ex_regwrite = 1;
        @(negedge CLK);
        chk("raw_x0_pc_en", pc_en_o[2], 1);

        // 4-bit counters: 20 stall cycles saturate, then clear during a stall
        step(); idle(); load_use();
        repeat (19) step();
        step(); perf_clr = 1;
        @(negedge CLK);
        chk("sat_stall_cnt", stall_o[3], 15);
        step(); idle();
        @(negedge CLK);
        chk("clr_stall_cnt", stall_o[3], 0);
        chk("clr_flush_cnt", flush_o[3], 0);

        repeat (4000) begin
            step();
            rand_inputs();
        end
        step();
        RESET_N = 1;
        idle();
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
